// File: rtl/dsp_interval_meter.sv
// Interval meter: counts enabled fast-clock cycles between a start and a
// stop event and reports the result in DELAY_SHIFT-scaled delay units.
module dsp_interval_meter #(
  parameter int DELAY_SHIFT = 0
) (
  input  logic        fast_clk_i,
  input  logic        fast_rst_i,
  input  logic        arm_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        count_enable_i,
  input  logic        ack_i,
  output logic [15:0] interval_o,
  output logic        valid_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int CW = 16 + DELAY_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COUNT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_scaled;
  logic            w_sat;
  logic [15:0]     r_interval;
  logic            r_ovf;

  // The stop cycle's own enable is folded in before latching.
  assign w_sat     = &r_cnt;
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + CW'(1);
  assign w_cnt_nxt = count_enable_i ? w_cnt_inc : r_cnt;
  assign w_scaled  = w_cnt_nxt >> DELAY_SHIFT;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (arm_i) w_next = S_ARMED;
      S_ARMED: if (start_i) w_next = S_COUNT;
      S_COUNT: if (stop_i) w_next = S_DONE;
      S_DONE: begin
        if (ack_i) w_next = arm_i ? S_ARMED : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_interval <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ARMED && start_i) begin
        r_cnt <= '0;
      end else if (r_state == S_COUNT) begin
        r_cnt <= w_cnt_nxt;
      end
      if (r_state == S_COUNT && stop_i) begin
        r_interval <= w_scaled[15:0];
        r_ovf      <= &w_cnt_nxt;
      end
    end
  end

  assign interval_o = r_interval;
  assign overflow_o = r_ovf;
  assign valid_o    = (r_state == S_DONE);
  assign busy_o     = (r_state == S_ARMED) || (r_state == S_COUNT);

endmodule

// File: tb/tb_dsp_interval_meter.sv
// Scoreboard bench for dsp_interval_meter at DELAY_SHIFT 0 and 2,
// both instances driven by the same stimulus.
module tb_dsp_interval_meter;

  localparam int SH = 2;

  logic clk = 1'b0;
  logic rst, arm, start, stop, en, ack;
  logic [15:0] iv0, iv2;
  logic vl0, vl2, of0, of2, bz0, bz2;

  always #5 clk = ~clk;

  dsp_interval_meter #(.DELAY_SHIFT(0)) u_dut0 (
    .fast_clk_i(clk), .fast_rst_i(rst), .arm_i(arm),
    .start_i(start), .stop_i(stop), .count_enable_i(en),
    .ack_i(ack), .interval_o(iv0), .valid_o(vl0),
    .overflow_o(of0), .busy_o(bz0)
  );

  dsp_interval_meter #(.DELAY_SHIFT(SH)) u_dut2 (
    .fast_clk_i(clk), .fast_rst_i(rst), .arm_i(arm),
    .start_i(start), .stop_i(stop), .count_enable_i(en),
    .ack_i(ack), .interval_o(iv2), .valid_o(vl2),
    .overflow_o(of2), .busy_o(bz2)
  );

  logic [16:0] q0[$];
  logic [16:0] q2[$];
  logic [16:0] x0, x2;
  logic p0 = 1'b0;
  logic p2 = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic a, input logic s,
                     input logic p, input logic e,
                     input logic k);
    arm = a; start = s; stop = p; en = e; ack = k;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] expect_res(input longint cnt,
                                             input int sh);
    longint mx;
    longint c;
    logic [15:0] iv;
    mx = (longint'(1) << (16 + sh)) - 1;
    c  = (cnt > mx) ? mx : cnt;
    iv = 16'((c >> sh) & 64'hFFFF);
    return {(c == mx), iv};
  endfunction

  task automatic push(input longint cnt);
    q0.push_back(expect_res(cnt, 0));
    q2.push_back(expect_res(cnt, SH));
  endtask

  // arm (unless already armed), gap cycles, start, then len cycles
  // with stop on the last; mode selects the enable pattern
  task automatic measure(input int len, input int mode,
                         input bit armed, input int gap);
    int   cnt;
    logic e;
    cnt = 0;
    if (!armed) begin
      cyc(1, 0, 0, 1, 0);
      check("busy_armed", bz0, 1);
    end
    repeat (gap) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, (mode == 2), 0);
    check("busy_count", bz0, 1);
    for (int c = 1; c <= len; c++) begin
      case (mode)
        0:       e = 1'b1;
        1:       e = 1'(c & 1);
        2:       e = 1'b0;
        default: e = 1'($urandom_range(0, 1));
      endcase
      cnt += int'(e);
      if (c == len) push(cnt);
      cyc(0, 0, (c == len), e, 0);
    end
    check("valid_done", vl0, 1);
    check("busy_done", bz0, 0);
  endtask

  task automatic do_ack();
    cyc(0, 0, 0, 0, 1);
    check("valid_ack", vl0, 0);
    check("busy_ack", bz0, 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (vl0 && !p0) begin
      if (q0.size() == 0) check("unexp_valid0", 1, 0);
      else begin
        x0 = q0.pop_front();
        check("interval_s0", iv0, x0[15:0]);
        check("overflow_s0", of0, x0[16]);
      end
    end
    if (vl2 && !p2) begin
      if (q2.size() == 0) check("unexp_valid2", 1, 0);
      else begin
        x2 = q2.pop_front();
        check("interval_s2", iv2, x2[15:0]);
        check("overflow_s2", of2, x2[16]);
      end
    end
    p0 = vl0;
    p2 = vl2;
  end

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_interval", iv0, 0);
    check("rst_valid", vl0, 0);
    check("rst_overflow", of0, 0);
    check("rst_busy", bz0, 0);
    check("rst_interval2", iv2, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    // ignored inputs in IDLE
    cyc(0, 1, 1, 1, 1);
    check("idle_ignore", bz0, 0);

    measure(5, 0, 0, 7);
    cyc(1, 0, 0, 0, 0);
    check("arm_noack", vl0, 1);
    do_ack();
    check("hold_idle", iv0, 5);
    cyc(1, 0, 0, 0, 0);
    check("hold_armed", iv0, 5);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("armed_stop_ign", bz0, 1);
    measure(5, 1, 1, 7);
    do_ack();

    measure(5, 2, 0, 7);
    do_ack();
    measure(13, 0, 0, 1);
    do_ack();
    measure(4096, 0, 0, 1);
    do_ack();
    measure(70000, 0, 0, 1);
    do_ack();
    measure(7, 0, 0, 1);
    do_ack();
    measure(40, 3, 0, 2);
    do_ack();

    // simultaneous start/stop in ARMED, then in COUNTING
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    check("ss_armed_busy", bz0, 1);
    check("ss_armed_valid", vl0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    push(3);
    cyc(0, 1, 1, 1, 0);
    check("ss_count_valid", vl0, 1);
    cyc(1, 0, 0, 0, 1);
    check("ackarm_valid", vl0, 0);
    check("ackarm_busy", bz0, 1);
    measure(4, 0, 1, 0);
    do_ack();

    // reset in the middle of a count
    measure(5, 0, 0, 2);
    do_ack();
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0);
    rst = 1'b0;
    check("mid_rst_interval", iv0, 0);
    check("mid_rst_overflow", of0, 0);
    check("mid_rst_busy", bz0, 0);
    check("mid_rst_valid", vl0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("post_rst_valid", vl0, 0);
    check("post_rst_busy", bz0, 0);

    cyc(0, 0, 0, 0, 0);
    check("queue_empty", q0.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
